// File: rtl/l2_mem_arbiter_if.sv
// Purpose: bundle of the two L2 miss/writeback ports and the shared off-chip memory port.
// Ports: i_* = L2-I line-fill side, d_* = L2-D fill/writeback side, mem_* = memory side.
// slave modport = arbiter view; master modport = surrounding caches + memory view.
interface l2_mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  // L2-I side
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ready;
  // L2-D side
  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              d_mem_ready;
  // memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_mem_read, i_mem_addr,
    input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    input  mem_rdata, mem_ready,
    output i_mem_rdata, i_mem_ready,
    output d_mem_rdata, d_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_mem_read, i_mem_addr,
    output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
    output mem_rdata, mem_ready,
    input  i_mem_rdata, i_mem_ready,
    input  d_mem_rdata, d_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l2_mem_arbiter.sv
// Purpose: round-robin share of one 128-bit memory port between L2-I (read) and L2-D (read/write).
// Latency: request -> memory strobe 1 cycle; mem_ready forwarded combinationally; 1 DONE cycle after.
// Backpressure: requesters hold strobes until their ready pulse; memory strobes held until mem_ready.
// Ports: clk, proc_reset_n (async, active-low), bus (l2_mem_arbiter_if.slave, all data/handshake).
module l2_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  l2_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q,   state_d;
  logic              last_d_q,  last_d_d;   // 1 = D side was granted most recently
  logic              op_wr_q,   op_wr_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;

  logic              req_i;
  logic              req_d;
  logic              busy;
  logic              fwd_rdata;
  logic [DATA_W-1:0] line;

  assign req_i = bus.i_mem_read;
  assign req_d = bus.d_mem_read | bus.d_mem_write;
  assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;   // pretend D went last so I wins the first tie
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d_d        = last_d_q;
    op_wr_d         = op_wr_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.i_mem_ready = 1'b0;
    bus.d_mem_ready = 1'b0;

    case (state_q)
      IDLE: begin
        // I wins when alone, or on a tie when D had the previous grant.
        if (req_i && (!req_d || last_d_q)) begin
          state_d  = BUSY_I;
          last_d_d = 1'b0;
          op_wr_d  = 1'b0;
          addr_d   = bus.i_mem_addr;
          wdata_d  = '0;
        end else if (req_d) begin
          state_d  = BUSY_D;
          last_d_d = 1'b1;
          op_wr_d  = bus.d_mem_write;   // write takes precedence over read
          addr_d   = bus.d_mem_addr;
          wdata_d  = bus.d_mem_wdata;
        end
      end

      BUSY_I, BUSY_D: begin
        bus.mem_read  = ~op_wr_q;
        bus.mem_write = op_wr_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        if (bus.mem_ready) begin
          bus.i_mem_ready = (state_q == BUSY_I);
          bus.d_mem_ready = (state_q == BUSY_D);
          rdata_d         = bus.mem_rdata;
          state_d         = DONE;
        end
      end

      // The completing cache still shows its strobe here; swallow it.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Caches sample rdata one cycle after ready, so the line is passed through
  // on the ready cycle and then held in rdata_q for the last-granted side.
  assign fwd_rdata = busy && bus.mem_ready;
  assign line      = fwd_rdata ? bus.mem_rdata : rdata_q;

  always_comb begin
    bus.i_mem_rdata = last_d_q ? '0   : line;
    bus.d_mem_rdata = last_d_q ? line : '0;
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Purpose: directed table-driven bench for l2_mem_arbiter plus fairness and reset sequences.
// Latency: one table row per clock; outputs sampled on the falling edge.
// Backpressure: bench plays both caches and the memory, holding strobes until ready.
module tb_l2_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  localparam logic [127:0] LA = {16{8'hA5}};
  localparam logic [127:0] LB = {4{32'hDEADBEEF}};
  localparam logic [127:0] LC = 128'h00C0FFEE;
  localparam logic [127:0] LE = 128'h0000E0E0;
  localparam logic [127:0] LF = 128'h0000F00D;
  localparam logic [127:0] LG = 128'h00006060;
  localparam logic [127:0] LH = 128'h00004848;

  logic clk;
  logic proc_reset_n;

  l2_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  l2_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ir;
    logic [27:0]  ia;
    logic         dr;
    logic         dw;
    logic [27:0]  da;
    logic [127:0] dwd;
    logic         mrdy;
    logic [127:0] mrd;
    logic [3:0]   es;    // {mem_read, mem_write, i_mem_ready, d_mem_ready}
    logic [27:0]  ea;
    logic [127:0] ewd;
    logic [127:0] eir;
    logic [127:0] edr;
  } vec_t;

  vec_t vecs[$];
  int   errs   = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic rst, input logic ir, input logic [27:0] ia,
                              input logic dr, input logic dw, input logic [27:0] da,
                              input logic [127:0] dwd, input logic mrdy, input logic [127:0] mrd,
                              input logic [3:0] es, input logic [27:0] ea, input logic [127:0] ewd,
                              input logic [127:0] eir, input logic [127:0] edr);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.mrdy = mrdy; v.mrd = mrd; v.es = es; v.ea = ea; v.ewd = ewd; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_mem_read  = 1'b0;
    bus.i_mem_addr  = '0;
    bus.d_mem_read  = 1'b0;
    bus.d_mem_write = 1'b0;
    bus.d_mem_addr  = '0;
    bus.d_mem_wdata = '0;
    bus.mem_ready   = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  task automatic check_outputs(input int idx, input logic [3:0] es, input logic [27:0] ea,
                               input logic [127:0] ewd, input logic [127:0] eir, input logic [127:0] edr);
    chk("strobes",   idx, {bus.mem_read, bus.mem_write, bus.i_mem_ready, bus.d_mem_ready}, es);
    chk("mem_addr",  idx, bus.mem_addr,    ea);
    chk("mem_wdata", idx, bus.mem_wdata,   ewd);
    chk("i_rdata",   idx, bus.i_mem_rdata, eir);
    chk("d_rdata",   idx, bus.d_mem_rdata, edr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       found;
    logic [1:0] exp_side;

    proc_reset_n = 1'b0;
    drive_idle();

    // Lone I read, memory answers on the 4th busy cycle.
    vecs.push_back(mk(1,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,0,0));
    vecs.push_back(mk(0,1,'h123,  0,0,0,0,   0,0,  4'b0000,0,0,0,0));
    vecs.push_back(mk(0,1,'h123,  0,0,0,0,   0,0,  4'b1000,'h123,0,0,0));
    vecs.push_back(mk(0,1,'h123,  0,0,0,0,   0,0,  4'b1000,'h123,0,0,0));
    vecs.push_back(mk(0,1,'h123,  0,0,0,0,   0,0,  4'b1000,'h123,0,0,0));
    vecs.push_back(mk(0,1,'h123,  0,0,0,0,   1,LA, 4'b1010,'h123,0,LA,0));
    vecs.push_back(mk(0,1,'h123,  0,0,0,0,   0,0,  4'b0000,0,0,LA,0));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,LA,0));
    // Simultaneous I read / D write after reset: I first, then the write.
    vecs.push_back(mk(1,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,0,0));
    vecs.push_back(mk(0,1,'h10,   0,1,'h20,1, 0,0, 4'b0000,0,0,0,0));
    vecs.push_back(mk(0,1,'h10,   0,1,'h20,1, 1,LB,4'b1010,'h10,0,LB,0));
    vecs.push_back(mk(0,1,'h10,   0,1,'h20,1, 0,0, 4'b0000,0,0,LB,0));
    vecs.push_back(mk(0,0,0,      0,1,'h20,1, 0,0, 4'b0000,0,0,LB,0));
    vecs.push_back(mk(0,0,0,      0,1,'h20,1, 0,0, 4'b0100,'h20,1,0,LB));
    vecs.push_back(mk(0,0,0,      0,1,'h20,1, 1,LC,4'b0101,'h20,1,0,LC));
    vecs.push_back(mk(0,0,0,      0,1,'h20,1, 0,0, 4'b0000,0,0,0,LC));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,0,LC));
    // D read and write together: write wins, single ready.
    vecs.push_back(mk(0,0,0,      1,1,'h30,5, 0,0, 4'b0000,0,0,0,LC));
    vecs.push_back(mk(0,0,0,      1,1,'h30,5, 0,0, 4'b0100,'h30,5,0,LC));
    vecs.push_back(mk(0,0,0,      1,1,'h30,5, 1,0, 4'b0101,'h30,5,0,0));
    vecs.push_back(mk(0,0,0,      1,1,'h30,5, 0,0, 4'b0000,0,0,0,0));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,0,0));
    // D busy while I waits; no ready leaks to I; DONE swallows strobes; I next.
    vecs.push_back(mk(0,0,0,      1,0,'h40,0, 0,0, 4'b0000,0,0,0,0));
    vecs.push_back(mk(0,1,'h50,   1,0,'h40,0, 0,0, 4'b1000,'h40,0,0,0));
    vecs.push_back(mk(0,1,'h50,   1,0,'h40,0, 1,LE,4'b1001,'h40,0,0,LE));
    vecs.push_back(mk(0,1,'h50,   1,0,'h40,0, 0,0, 4'b0000,0,0,0,LE));
    vecs.push_back(mk(0,1,'h50,   1,0,'h40,0, 0,0, 4'b0000,0,0,0,LE));
    vecs.push_back(mk(0,1,'h50,   1,0,'h40,0, 0,0, 4'b1000,'h50,0,LE,0));
    vecs.push_back(mk(0,1,'h50,   1,0,'h40,0, 1,LF,4'b1010,'h50,0,LF,0));
    vecs.push_back(mk(0,1,'h50,   1,0,'h40,0, 0,0, 4'b0000,0,0,LF,0));
    vecs.push_back(mk(0,0,0,      1,0,'h40,0, 0,0, 4'b0000,0,0,LF,0));
    vecs.push_back(mk(0,0,0,      1,0,'h40,0, 1,LG,4'b1001,'h40,0,0,LG));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,0,LG));
    // Stray mem_ready in IDLE: ignored, held line unchanged.
    vecs.push_back(mk(0,0,0,      0,0,0,0,   1,LH, 4'b0000,0,0,0,LG));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,0,LG));
    // I drops its strobe mid-access: access still completes with a ready.
    vecs.push_back(mk(0,1,'h60,   0,0,0,0,   0,0,  4'b0000,0,0,0,LG));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   0,0,  4'b1000,'h60,0,LG,0));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   1,LA, 4'b1010,'h60,0,LA,0));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,LA,0));
    vecs.push_back(mk(0,0,0,      0,0,0,0,   0,0,  4'b0000,0,0,LA,0));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      proc_reset_n    = ~vecs[i].rst;
      bus.i_mem_read  = vecs[i].ir;
      bus.i_mem_addr  = vecs[i].ia;
      bus.d_mem_read  = vecs[i].dr;
      bus.d_mem_write = vecs[i].dw;
      bus.d_mem_addr  = vecs[i].da;
      bus.d_mem_wdata = vecs[i].dwd;
      bus.mem_ready   = vecs[i].mrdy;
      bus.mem_rdata   = vecs[i].mrd;
      @(negedge clk);
      check_outputs(i, vecs[i].es, vecs[i].ea, vecs[i].ewd, vecs[i].eir, vecs[i].edr);
      @(posedge clk); #1;
    end

    // Fairness: both sides request continuously, grants must alternate I,D,I,D,I,D.
    drive_idle();
    proc_reset_n = 1'b0;
    @(posedge clk); #1;
    proc_reset_n    = 1'b1;
    bus.i_mem_read  = 1'b1;
    bus.i_mem_addr  = 28'h100;
    bus.d_mem_read  = 1'b1;
    bus.d_mem_addr  = 28'h200;
    for (int t = 0; t < 6; t++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (bus.mem_read || bus.mem_write) found = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      if (!found) begin
        checks++;
        errs++;
        $display("FAIL fair_timeout txn %0d: got no strobe expected a grant within 20 cycles", t);
      end else begin
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 128'(t);
        @(negedge clk);
        exp_side = (t % 2 == 0) ? 2'b10 : 2'b01;
        chk("fair_grant", t, {bus.i_mem_ready, bus.d_mem_ready}, exp_side);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
      end
    end

    // Reset mid-BUSY_I with mem_ready high: everything drops at once.
    drive_idle();
    proc_reset_n = 1'b0;
    @(posedge clk); #1;
    proc_reset_n   = 1'b1;
    bus.i_mem_read = 1'b1;
    bus.i_mem_addr = 28'h70;
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = LA;
    #1;
    check_outputs(100, 4'b1010, 28'h70, '0, LA, '0);
    proc_reset_n = 1'b0;
    #1;
    check_outputs(101, 4'b0000, '0, '0, '0, '0);
    drive_idle();
    @(posedge clk); #1;
    proc_reset_n    = 1'b1;
    bus.d_mem_read  = 1'b1;
    bus.d_mem_addr  = 28'h80;
    @(negedge clk);
    check_outputs(102, 4'b0000, '0, '0, '0, '0);
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs(103, 4'b1000, 28'h80, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
